data_bus_arbiter: RTL and testbench
===================================

// Module: data_bus_arbiter
// PURPOSE
//  Shares the processor's single data-side port (address, write data, read data, write strobe)
//  between two requesters: m0 = processor data port, m1 = secondary master (loader/debug/DMA).
//  Round-robin arbitration, one transfer in flight, fixed wait states toward memory.
//  Sits between the processor/secondary master and the data memory/peripheral bus.
// PARAMETERS
//  ADDR_W   32  address width of all ports
//  DATA_W   32  data width of all ports
//  MEM_LAT  1   cycles mem_addr is held before mem_rdata is sampled; legal 1..15
// PORTS
//  clk        in   1       single system clock, all logic on rising edge
//  rst        in   1       asynchronous, active-low reset
//  m0_req     in   1       m0 transfer request (level)
//  m0_wr      in   1       m0 direction: 1 = write, 0 = read
//  m0_addr    in   ADDR_W  m0 address
//  m0_wdata   in   DATA_W  m0 write data
//  m0_rdata   out  DATA_W  m0 read data, valid while m0_ack=1
//  m0_ack     out  1       one-cycle completion pulse to m0
//  m1_*       same set as m0_* for requester m1
//  mem_addr   out  ADDR_W  address to data memory
//  mem_wdata  out  DATA_W  write data to data memory
//  mem_wr     out  1       memory write strobe
//  mem_rdata  in   DATA_W  read data from data memory
//  owner      out  1       requester currently granted (0 = m0, 1 = m1); meaningful while busy=1
//  busy       out  1       1 from grant until the ack cycle, inclusive
// BEHAVIOUR
//  Reset (rst=0, asynchronous): state=IDLE, prio=m0, wait counter=0; all outputs 0
//   (mem_addr, mem_wdata, mem_wr, m*_rdata, m*_ack, owner, busy). An in-flight transfer is
//   aborted: no ack, mem_wr drops immediately, no partial write is repeated after release.
//  FSM: IDLE -> ACCESS -> RESP -> IDLE.
//   IDLE: at an edge with any req=1, grant the requester; if both, grant prio. Latch wr, addr,
//    wdata of the winner; counter=MEM_LAT-1; go ACCESS. No req: stay IDLE.
//   ACCESS: mem_addr/mem_wdata driven from the latches for all MEM_LAT cycles. mem_wr=latched wr
//    on the first ACCESS cycle only (exactly one write strobe per transfer). Counter decrements
//    each edge; at the edge where counter=0, capture mem_rdata into the owner's rdata reg, go RESP.
//   RESP: owner's ack=1 for exactly this cycle; rdata holds the captured value (also for writes,
//    where it carries don't-care memory data). prio <- other requester. Go IDLE.
//  Latency: req seen at edge k -> ack high in the cycle after edge k+MEM_LAT+1.
//   MEM_LAT=1: 3-edge round trip, 1 idle cycle between back-to-back transfers.
//  Requester rules: hold req, wr, addr, wdata stable until ack. Inputs changing after the grant edge
//   are ignored. A req still high at the first IDLE edge after ack is a new request.
//  Fairness: with both requesting continuously, grants alternate m0,m1,m0,...; worst-case wait for
//   either requester = one foreign transfer.
//  The non-owner's ack is never asserted. Its rdata holds its last value.
//  Outside ACCESS: mem_wr=0; mem_addr/mem_wdata hold the last driven value.
//  Widths: addresses and data pass unmodified, no alignment or byte lanes. Counter width 4.
// STRUCTURE
//  Shared package dba_pkg: FSM state encoding (IDLE/ACCESS/RESP) and owner constants OWN_M0/OWN_M1.
//  One natural sub-module: dba_rr_pick (combinational: req0, req1, prio -> grant valid, grant id).
//   FSM, latches and counter stay in data_bus_arbiter.
// TESTING
//  Reset: rst=0 mid-bench -> all outputs 0 the same cycle; after release, first grant with both
//   req=1 goes to m0.
//  m0 read, MEM_LAT=1: addr=0x0000_0010, mem returns 0xDEAD_BEEF -> m0_ack pulses 1 cycle with
//   m0_rdata=0xDEAD_BEEF, 3 edges after req sampled; m1_ack stays 0.
//  m1 write, MEM_LAT=3: addr=0x20, wdata=0x1234_5678 -> mem_wr high exactly 1 cycle with
//   mem_addr=0x20, mem_wdata=0x1234_5678; addr held 3 cycles; ack 5 edges after req.
//  Contention: m0 and m1 both hold req for 6 transfers -> grant order m0,m1,m0,m1,m0,m1; owner
//   matches the acked requester each time.
//  Input change after grant: m0 changes addr 0x40 -> 0x80 one cycle after grant -> memory sees
//   0x40 only.
//  Reset mid-ACCESS (MEM_LAT=4, write in flight): rst low in cycle 2 -> no ack, mem_wr=0; after
//   release, held req is re-arbitrated from IDLE and completes normally.

Source files
------------

// File: rtl/dba_pkg.sv
// Shared FSM encoding, owner ids and counter width for the data-side bus arbiter.
package dba_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic OWN_M0 = 1'b0;
  localparam logic OWN_M1 = 1'b1;

  // Round-robin successor: priority moves to the requester that did not just finish.
  function automatic logic other_owner(input logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/dba_rr_pick.sv
// Two-way round-robin pick: grants the lone requester, or the priority holder on contention.
module dba_rr_pick
  import dba_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic prio_i,
  output logic gnt_vld_c_o,
  output logic gnt_id_c_o
);

  always_comb begin
    gnt_vld_c_o = req0_i | req1_i;
    gnt_id_c_o  = OWN_M0;
    if (req0_i && req1_i) begin
      gnt_id_c_o = prio_i;
    end else if (req1_i) begin
      gnt_id_c_o = OWN_M1;
    end
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Shares the single data-memory port between the processor (m0) and a secondary master (m1),
// one transfer in flight, round-robin on contention, fixed MEM_LAT wait states.
module data_bus_arbiter
  import dba_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              prio_q, prio_d;
  logic              owner_q, owner_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_wr_q, mem_wr_d;
  logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
  logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
  logic              m0_ack_q, m0_ack_d;
  logic              m1_ack_q, m1_ack_d;
  logic              gnt_vld_c;
  logic              gnt_id_c;

  dba_rr_pick u_pick (
    .req0_i      (m0_req),
    .req1_i      (m1_req),
    .prio_i      (prio_q),
    .gnt_vld_c_o (gnt_vld_c),
    .gnt_id_c_o  (gnt_id_c)
  );

  // mem_addr/mem_wdata registers double as the request latches: loaded once at grant.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    prio_d      = prio_q;
    owner_d     = owner_q;
    busy_d      = busy_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wr_d    = 1'b0;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    m0_ack_d    = 1'b0;
    m1_ack_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        busy_d = gnt_vld_c;
        if (gnt_vld_c) begin
          state_d = ST_ACCESS;
          owner_d = gnt_id_c;
          cnt_d   = CNT_W'(MEM_LAT - 1);
          if (gnt_id_c == OWN_M1) begin
            mem_addr_d  = m1_addr;
            mem_wdata_d = m1_wdata;
            mem_wr_d    = m1_wr;
          end else begin
            mem_addr_d  = m0_addr;
            mem_wdata_d = m0_wdata;
            mem_wr_d    = m0_wr;
          end
        end
      end

      ST_ACCESS: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = ST_RESP;
          cnt_d   = cnt_q;
          if (owner_q == OWN_M1) begin
            m1_rdata_d = mem_rdata;
          end else begin
            m0_rdata_d = mem_rdata;
          end
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
        prio_d  = other_owner(owner_q);
        if (owner_q == OWN_M1) begin
          m1_ack_d = 1'b1;
        end else begin
          m0_ack_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      prio_q      <= OWN_M0;
      owner_q     <= OWN_M0;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wr_q    <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
      m0_ack_q    <= 1'b0;
      m1_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      prio_q      <= prio_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wr_q    <= mem_wr_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
      m0_ack_q    <= m0_ack_d;
      m1_ack_q    <= m1_ack_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wr    = mem_wr_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign m0_ack    = m0_ack_q;
  assign m1_ack    = m1_ack_q;
  assign owner     = owner_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Bench for data_bus_arbiter: three instances (MEM_LAT 1, 3, 4) checked every cycle
// against a transaction-timeline model, plus directed vectors and corner sequences.
module tb_data_bus_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int NI = 3;

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 3 : 4);
  endfunction

  // Memory contents as seen by the arbiter: fixed scramble of the address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  logic clk = 1'b0;
  logic rst;
  logic        req   [NI][2];
  logic        wr    [NI][2];
  logic [31:0] addr  [NI][2];
  logic [31:0] wdata [NI][2];
  logic [31:0] rdata [NI][2];
  logic        ack   [NI][2];
  logic [31:0] mem_addr  [NI];
  logic [31:0] mem_wdata [NI];
  logic [31:0] mem_rdata [NI];
  logic        mem_wr    [NI];
  logic        owner     [NI];
  logic        busy      [NI];
  logic        ovr_en    [NI];
  logic [31:0] ovr_val   [NI];

  initial forever #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NI; i++) begin
      mem_rdata[i] = ovr_en[i] ? ovr_val[i] : mem_fn(mem_addr[i]);
    end
  end

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    data_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .m0_req    (req[g][0]),
      .m0_wr     (wr[g][0]),
      .m0_addr   (addr[g][0]),
      .m0_wdata  (wdata[g][0]),
      .m0_rdata  (rdata[g][0]),
      .m0_ack    (ack[g][0]),
      .m1_req    (req[g][1]),
      .m1_wr     (wr[g][1]),
      .m1_addr   (addr[g][1]),
      .m1_wdata  (wdata[g][1]),
      .m1_rdata  (rdata[g][1]),
      .m1_ack    (ack[g][1]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_wr    (mem_wr[g]),
      .mem_rdata (mem_rdata[g]),
      .owner     (owner[g]),
      .busy      (busy[g])
    );
  end

  int n_chk;
  int n_pass;

  function automatic void chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h want 0x%08h", nm, got, exp);
  endfunction

  // Model: the last granted transfer per instance plus edge arithmetic decides every output.
  int          cyc;
  bit          has     [NI];
  bit          t_own   [NI];
  bit          t_wr    [NI];
  logic [31:0] t_addr  [NI];
  logic [31:0] t_wdata [NI];
  int          t_grant [NI];
  bit          prio_m  [NI];
  logic [31:0] exp_rd  [NI][2];

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      has[i] = 1'b0; t_own[i] = 1'b0; t_wr[i] = 1'b0; prio_m[i] = 1'b0;
      t_addr[i] = '0; t_wdata[i] = '0; t_grant[i] = 0;
      exp_rd[i][0] = '0; exp_rd[i][1] = '0;
    end
  endtask

  task automatic model_step();
    cyc++;
    if (rst) begin
      for (int i = 0; i < NI; i++) begin
        int L;
        bit w;
        L = lat_of(i);
        if (has[i] && cyc == t_grant[i] + L)
          exp_rd[i][t_own[i]] = ovr_en[i] ? ovr_val[i] : mem_fn(t_addr[i]);
        if ((!has[i] || cyc >= t_grant[i] + L + 2) && (req[i][0] || req[i][1])) begin
          w = (req[i][0] && req[i][1]) ? prio_m[i] : req[i][1];
          has[i] = 1'b1; t_own[i] = w; t_wr[i] = wr[i][w];
          t_addr[i] = addr[i][w]; t_wdata[i] = wdata[i][w];
          t_grant[i] = cyc; prio_m[i] = ~w;
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < NI; i++) begin
      int L;
      L = lat_of(i);
      chk($sformatf("i%0d busy", i), 32'(busy[i]), 32'(has[i] && cyc <= t_grant[i] + L + 1));
      chk($sformatf("i%0d owner", i), 32'(owner[i]), 32'(has[i] ? t_own[i] : 1'b0));
      chk($sformatf("i%0d mem_addr", i), mem_addr[i], has[i] ? t_addr[i] : 32'h0);
      chk($sformatf("i%0d mem_wdata", i), mem_wdata[i], has[i] ? t_wdata[i] : 32'h0);
      chk($sformatf("i%0d mem_wr", i), 32'(mem_wr[i]), 32'(has[i] && cyc == t_grant[i] && t_wr[i]));
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("i%0d m%0d_ack", i, m), 32'(ack[i][m]),
            32'(has[i] && cyc == t_grant[i] + L + 1 && int'(t_own[i]) == m));
        chk($sformatf("i%0d m%0d_rdata", i, m), rdata[i][m], exp_rd[i][m]);
      end
    end
  endtask

  task automatic step_cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic rand_payload(input int i, input int m);
    wr[i][m]    = 1'($urandom_range(0, 1));
    addr[i][m]  = $urandom;
    wdata[i][m] = $urandom;
  endtask

  typedef struct {
    int          inst;
    int          m;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem;
    int          exp_edges;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [5];

  task automatic run_vec(input vec_t v, input int idx);
    int i, n, pulses;
    bit got_ack, addr_ok;
    i = v.inst;
    ovr_en[i] = 1'b1; ovr_val[i] = v.mem;
    req[i][v.m] = 1'b1; wr[i][v.m] = v.wr; addr[i][v.m] = v.addr; wdata[i][v.m] = v.wdata;
    n = 0; pulses = 0; got_ack = 1'b0; addr_ok = 1'b1;
    while (!got_ack && n < 20) begin
      step_cycle();
      n++;
      if (mem_addr[i] !== v.addr) addr_ok = 1'b0;
      if (mem_wr[i]) begin
        pulses++;
        chk($sformatf("vec%0d strobe wdata", idx), mem_wdata[i], v.wdata);
      end
      if (ack[i][v.m]) got_ack = 1'b1;
    end
    chk($sformatf("vec%0d ack latency", idx), 32'(n), 32'(v.exp_edges));
    chk($sformatf("vec%0d other ack", idx), 32'(ack[i][1 - v.m]), 32'h0);
    chk($sformatf("vec%0d owner", idx), 32'(owner[i]), 32'(v.m));
    chk($sformatf("vec%0d wr pulses", idx), 32'(pulses), 32'(v.wr));
    chk($sformatf("vec%0d addr held", idx), 32'(addr_ok), 32'h1);
    if (!v.wr) chk($sformatf("vec%0d rdata", idx), rdata[i][v.m], v.exp_rdata);
    req[i][v.m] = 1'b0;
    step_cycle();
    ovr_en[i] = 1'b0;
    chk($sformatf("vec%0d ack drop", idx), 32'(ack[i][v.m]), 32'h0);
    chk($sformatf("vec%0d busy drop", idx), 32'(busy[i]), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n, pulses;
    bit who, bad;

    vecs[0] = '{0, 0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 3, 32'hDEAD_BEEF};
    vecs[1] = '{1, 1, 1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0,         5, 32'h0};
    vecs[2] = '{2, 0, 1'b0, 32'h0000_0044, 32'h0,         32'h0BAD_F00D, 6, 32'h0BAD_F00D};
    vecs[3] = '{0, 1, 1'b0, 32'h3000_0000, 32'h0,         32'hCAFE_0001, 3, 32'hCAFE_0001};
    vecs[4] = '{1, 0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'h0,         5, 32'h0};

    n_chk = 0; n_pass = 0; cyc = 0;
    for (int i = 0; i < NI; i++) begin
      ovr_en[i] = 1'b0; ovr_val[i] = '0;
      for (int m = 0; m < 2; m++) begin
        req[i][m] = 1'b0; wr[i][m] = 1'b0; addr[i][m] = '0; wdata[i][m] = '0;
      end
    end
    rst = 1'b0;
    model_reset();
    repeat (2) step_cycle();
    rst = 1'b1;
    repeat (2) step_cycle();

    for (int v = 0; v < 5; v++) run_vec(vecs[v], v);

    // Reset mid-bench: outputs clear immediately, then contention starts at m0.
    req[0][0] = 1'b1; wr[0][0] = 1'b0; addr[0][0] = 32'h0000_0100;
    req[0][1] = 1'b1; wr[0][1] = 1'b0; addr[0][1] = 32'h0000_0200;
    rst = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst i%0d busy", i), 32'(busy[i]), 32'h0);
      chk($sformatf("rst i%0d mem_addr", i), mem_addr[i], 32'h0);
      chk($sformatf("rst i%0d mem_wdata", i), mem_wdata[i], 32'h0);
      chk($sformatf("rst i%0d m0_rdata", i), rdata[i][0], 32'h0);
      chk($sformatf("rst i%0d m1_rdata", i), rdata[i][1], 32'h0);
    end
    check_all();
    step_cycle();
    rst = 1'b1;
    k = 0; n = 0;
    while (k < 6 && n < 100) begin
      step_cycle();
      n++;
      if (ack[0][0] || ack[0][1]) begin
        who = ack[0][1];
        chk($sformatf("rr order %0d", k), 32'(who), 32'(k % 2));
        chk($sformatf("rr owner %0d", k), 32'(owner[0]), 32'(who));
        chk($sformatf("rr single ack %0d", k), 32'(ack[0][0] & ack[0][1]), 32'h0);
        chk($sformatf("rr rdata %0d", k), rdata[0][who], who ? mem_fn(32'h200) : mem_fn(32'h100));
        k++;
        if (k == 6) begin
          req[0][0] = 1'b0; req[0][1] = 1'b0;
        end
      end
    end
    chk("rr transfer count", 32'(k), 32'd6);
    repeat (2) step_cycle();

    // Address change one cycle after grant must not reach memory.
    req[0][0] = 1'b1; wr[0][0] = 1'b0; addr[0][0] = 32'h0000_0040;
    step_cycle();
    chk("chg grant busy", 32'(busy[0]), 32'h1);
    chk("chg grant addr", mem_addr[0], 32'h0000_0040);
    addr[0][0] = 32'h0000_0080;
    n = 0; bad = 1'b0;
    while (!ack[0][0] && n < 10) begin
      step_cycle();
      n++;
      if (mem_addr[0] !== 32'h0000_0040) bad = 1'b1;
    end
    chk("chg addr stable", 32'(bad), 32'h0);
    chk("chg ack seen", 32'(ack[0][0]), 32'h1);
    chk("chg rdata", rdata[0][0], mem_fn(32'h0000_0040));
    req[0][0] = 1'b0;
    repeat (2) step_cycle();

    // Reset while a MEM_LAT=4 write is in its second ACCESS cycle.
    req[2][1] = 1'b1; wr[2][1] = 1'b1; addr[2][1] = 32'h0000_0060; wdata[2][1] = 32'hA5A5_A5A5;
    step_cycle();
    chk("rma first strobe", 32'(mem_wr[2]), 32'h1);
    step_cycle();
    rst = 1'b0;
    model_reset();
    #1;
    chk("rma mem_wr", 32'(mem_wr[2]), 32'h0);
    chk("rma ack", 32'(ack[2][1]), 32'h0);
    chk("rma busy", 32'(busy[2]), 32'h0);
    check_all();
    step_cycle();
    rst = 1'b1;
    n = 0; pulses = 0;
    while (!ack[2][1] && n < 20) begin
      step_cycle();
      n++;
      if (mem_wr[2]) begin
        pulses++;
        chk("rma restart addr", mem_addr[2], 32'h0000_0060);
        chk("rma restart wdata", mem_wdata[2], 32'hA5A5_A5A5);
      end
    end
    chk("rma restart latency", 32'(n), 32'd6);
    chk("rma restart strobes", 32'(pulses), 32'd1);
    req[2][1] = 1'b0;
    repeat (2) step_cycle();

    // Random traffic with occasional asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      step_cycle();
      if (!rst) rst = 1'b1;
      for (int i = 0; i < NI; i++) begin
        for (int m = 0; m < 2; m++) begin
          if (!req[i][m]) begin
            if ($urandom_range(0, 2) == 0) begin
              req[i][m] = 1'b1;
              rand_payload(i, m);
            end
          end else if (ack[i][m]) begin
            if ($urandom_range(0, 1) == 0) req[i][m] = 1'b0;
            else rand_payload(i, m);
          end else if (has[i] && int'(t_own[i]) == m && $urandom_range(0, 3) == 0) begin
            rand_payload(i, m);
          end
        end
      end
      if ($urandom_range(0, 499) == 0) begin
        rst = 1'b0;
        model_reset();
        #1;
        check_all();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
